// File: rtl/text_console_ctrl.sv
// -----------------------------------------------------------------------------
// text_console_ctrl
//   Character screen buffer controller between a UART receiver and an ASCII
//   text renderer. Interprets received bytes (printable codes, CR, LF, BS, FF),
//   owns the COLS x ROWS character RAM and the cursor, and serves a registered
//   read port to the VGA text generator.
//
//   Optional feature: define TEXT_ECHO_EN to echo every byte acted upon to the
//   UART transmitter (tx_start/tx_data) whenever tx_busy is low. Without the
//   macro tx_start/tx_data are tied to zero and tx_busy is ignored.
//
// Ports
//   clk       system clock
//   reset     synchronous, active-high; restarts a full-screen clear
//   rx_valid  one-cycle strobe, rx_data holds a new byte
//   rx_data   received byte
//   rd_col    renderer column (>= COLS reads BLANK_CHAR)
//   rd_row    renderer row    (>= ROWS reads BLANK_CHAR)
//   rd_char   RAM[rd_row][rd_col], one-cycle latency, old data on collision
//   cur_col   cursor column
//   cur_row   cursor row
//   busy      controller is writing or clearing
//   overrun   sticky: a byte was dropped; cleared by reset or form feed
//   tx_start  echo strobe to the UART transmitter
//   tx_data   echo byte
//   tx_busy   UART transmitter busy
// -----------------------------------------------------------------------------
module text_console_ctrl #(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 30,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic [6:0] rd_col,
    input  logic [4:0] rd_row,
    output logic [7:0] rd_char,
    output logic [6:0] cur_col,
    output logic [4:0] cur_row,
    output logic       busy,
    output logic       overrun,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy
);
    localparam int              CELLS     = COLS * ROWS;
    localparam int              AW        = $clog2(CELLS);
    localparam logic [6:0]      COL_LAST  = 7'(COLS - 1);
    localparam logic [4:0]      ROW_LAST  = 5'(ROWS - 1);
    localparam logic [AW-1:0]   CELL_LAST = AW'(CELLS - 1);
    localparam logic [AW-1:0]   LINE_LAST = AW'(COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_CLR_LINE,
        S_CLR_ALL
    } state_t;

    state_t        state;
    logic [7:0]    ram [CELLS];
    logic [7:0]    byte_p0;     // byte being acted on in S_WRITE
    logic [7:0]    hold_data;
    logic          hold_full;
    logic [AW-1:0] clr_cnt;     // column in S_CLR_LINE, linear cell in S_CLR_ALL

    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          rd_oor;

    function automatic logic [AW-1:0] lin_addr(input logic [4:0] row, input logic [6:0] col);
        return AW'(row) * AW'(COLS) + AW'(col);
    endfunction

    // Row wraps to the top: there is no scrolling.
    function automatic logic [4:0] next_row(input logic [4:0] row);
        return (row == ROW_LAST) ? 5'd0 : row + 5'd1;
    endfunction

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    assign busy = (state != S_IDLE);

    // Single write port shared by byte actions and the two clear sweeps.
    always_comb begin
        we    = 1'b0;
        waddr = lin_addr(cur_row, cur_col);
        wdata = BLANK_CHAR;
        case (state)
            S_CLR_ALL: begin
                we    = 1'b1;
                waddr = clr_cnt;
            end
            S_CLR_LINE: begin
                we    = 1'b1;
                waddr = lin_addr(cur_row, 7'(clr_cnt));
            end
            S_WRITE: begin
                if (is_printable(byte_p0)) begin
                    we    = 1'b1;
                    wdata = byte_p0;
                end else if (byte_p0 == 8'h08 && cur_col != 7'd0) begin
                    we    = 1'b1;
                    waddr = lin_addr(cur_row, cur_col - 7'd1);
                end
            end
            default: ;
        endcase
        if (reset) we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (we) ram[waddr] <= wdata;
    end

    // Read port: the RAM array is read before this edge's write lands, so a
    // same-cell collision returns the previous contents.
    assign rd_oor = (rd_col > COL_LAST) || (rd_row > ROW_LAST);

    always_ff @(posedge clk) begin
        if (reset)       rd_char <= 8'h00;
        else if (rd_oor) rd_char <= BLANK_CHAR;
        else             rd_char <= ram[lin_addr(rd_row, rd_col)];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_CLR_ALL;
            clr_cnt   <= '0;
            cur_col   <= 7'd0;
            cur_row   <= 5'd0;
            hold_full <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // The held byte is older, so it goes first; a byte
                    // arriving in the same cycle refills the hold.
                    if (hold_full) begin
                        byte_p0 <= hold_data;
                        state   <= S_WRITE;
                        if (rx_valid) hold_data <= rx_data;
                        else          hold_full <= 1'b0;
                    end else if (rx_valid) begin
                        byte_p0 <= rx_data;
                        state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    state <= S_IDLE;
                    if (is_printable(byte_p0)) begin
                        if (cur_col == COL_LAST) begin
                            cur_col <= 7'd0;
                            cur_row <= next_row(cur_row);
                            clr_cnt <= '0;
                            state   <= S_CLR_LINE;
                        end else begin
                            cur_col <= cur_col + 7'd1;
                        end
                    end else begin
                        case (byte_p0)
                            8'h0D: cur_col <= 7'd0;
                            8'h0A: begin
                                cur_row <= next_row(cur_row);
                                clr_cnt <= '0;
                                state   <= S_CLR_LINE;
                            end
                            8'h08: if (cur_col != 7'd0) cur_col <= cur_col - 7'd1;
                            8'h0C: begin
                                overrun <= 1'b0;
                                clr_cnt <= '0;
                                state   <= S_CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CLR_LINE: begin
                    if (clr_cnt == LINE_LAST) state   <= S_IDLE;
                    else                      clr_cnt <= clr_cnt + AW'(1);
                end
                S_CLR_ALL: begin
                    if (clr_cnt == CELL_LAST) begin
                        state   <= S_IDLE;
                        cur_col <= 7'd0;
                        cur_row <= 5'd0;
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Intake while busy; placed last so a drop in the same cycle as a
            // form feed leaves overrun set.
            if (state != S_IDLE && rx_valid) begin
                if (!hold_full) begin
                    hold_full <= 1'b1;
                    hold_data <= rx_data;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

`ifdef TEXT_ECHO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            if (state == S_WRITE && !tx_busy) begin
                tx_start <= 1'b1;
                tx_data  <= byte_p0;
            end
        end
    end
`else
    logic unused_tx_busy;
    assign unused_tx_busy = tx_busy;
    assign tx_start       = 1'b0;
    assign tx_data        = 8'h00;
`endif

endmodule

// File: tb/tb_text_console_ctrl.sv
module tb_text_console_ctrl;
    localparam int         COLS  = 80;
    localparam int         ROWS  = 30;
    localparam logic [7:0] BLANK = 8'h20;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [6:0] rd_col;
    logic [4:0] rd_row;
    logic [7:0] rd_char;
    logic [6:0] cur_col;
    logic [4:0] cur_row;
    logic       busy;
    logic       overrun;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    always #5 clk = ~clk;

    text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLANK_CHAR(BLANK)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rd_col(rd_col), .rd_row(rd_row), .rd_char(rd_char),
        .cur_col(cur_col), .cur_row(cur_row), .busy(busy), .overrun(overrun),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 50)
                $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline reference model ----------------
    // Screen image plus the edge numbers at which each activity happens.
    logic [7:0] scr   [ROWS][COLS];
    bit         known [ROWS][COLS];
    bit         m_valid = 0;
    int         m_col, m_row;
    bit         m_ovr, m_busy, m_txs, m_rd_known;
    logic [7:0] m_rd, m_txd;
    int         free_edge;           // first edge at which a new byte can be taken
    int         pend_edge = -100000; // edge at which the accepted byte is acted on
    logic [7:0] pend_b;
    bit         hold_v;
    logic [7:0] hold_b;
    int         line_start = -100000, line_row;
    int         all_start  = -100000;
    int         edge_n = 0;

    task automatic put(input int r, input int c, input logic [7:0] v);
        scr[r][c]   = v;
        known[r][c] = 1'b1;
    endtask

    task automatic newline(input int e);
        m_row      = (m_row + 1) % ROWS;
        line_row   = m_row;
        line_start = e + 1;
        free_edge  = e + 1 + COLS;
    endtask

    task automatic act(input int e, input logic [7:0] b);
`ifdef TEXT_ECHO_EN
        if (!tx_busy) begin
            m_txs = 1'b1;
            m_txd = b;
        end
`endif
        if (b >= 8'h20 && b <= 8'h7E) begin
            put(m_row, m_col, b);
            if (m_col == COLS - 1) begin
                m_col = 0;
                newline(e);
            end else begin
                m_col++;
            end
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            newline(e);
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                put(m_row, m_col, BLANK);
            end
        end else if (b == 8'h0C) begin
            m_ovr     = 1'b0;
            all_start = e + 1;
            free_edge = e + 1 + ROWS * COLS;
        end
    endtask

    task automatic take(input int e, input logic [7:0] b);
        pend_edge = e + 1;
        pend_b    = b;
        free_edge = e + 2;
    endtask

    task automatic model_step(input int e);
        int r, c, k;
        if (reset) begin
            m_valid    = 1'b1;
            m_col      = 0;
            m_row      = 0;
            m_ovr      = 1'b0;
            hold_v     = 1'b0;
            pend_edge  = -100000;
            line_start = -100000;
            all_start  = e + 1;
            free_edge  = e + 1 + ROWS * COLS;
            m_rd       = 8'h00;
            m_rd_known = 1'b1;
            m_txs      = 1'b0;
            m_txd      = 8'h00;
        end else if (m_valid) begin
            r = int'(rd_row);
            c = int'(rd_col);
            if (r >= ROWS || c >= COLS) begin
                m_rd       = BLANK;
                m_rd_known = 1'b1;
            end else begin
                m_rd       = scr[r][c];
                m_rd_known = known[r][c];
            end
            m_txs = 1'b0;
            if (e >= line_start && e < line_start + COLS) put(line_row, e - line_start, BLANK);
            if (e >= all_start && e < all_start + ROWS * COLS) begin
                k = e - all_start;
                put(k / COLS, k % COLS, BLANK);
            end
            if (e == all_start + ROWS * COLS - 1) begin
                m_col = 0;
                m_row = 0;
            end
            if (e == pend_edge) act(e, pend_b);
            if (e >= free_edge) begin
                if (hold_v) begin
                    take(e, hold_b);
                    if (rx_valid) hold_b = rx_data;
                    else          hold_v = 1'b0;
                end else if (rx_valid) begin
                    take(e, rx_data);
                end
            end else if (rx_valid) begin
                if (!hold_v) begin
                    hold_v = 1'b1;
                    hold_b = rx_data;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
        m_busy = (e + 1 < free_edge);
    endtask

    // Compare process: model advances on each edge, DUT sampled 1 time unit later.
    always @(posedge clk) begin
        model_step(edge_n);
        edge_n++;
        #1;
        if (m_valid) begin
            chk("cur_col", 32'(cur_col), 32'(m_col));
            chk("cur_row", 32'(cur_row), 32'(m_row));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("tx_start", 32'(tx_start), 32'(m_txs));
            chk("tx_data", 32'(tx_data), 32'(m_txd));
            if (m_rd_known) chk("rd_char", 32'(rd_char), 32'(m_rd));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy !== 1'b0) chk("wait_idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic read_chk(input string nm, input int r, input int c, input logic [7:0] exp);
        rd_row = 5'(r);
        rd_col = 7'(c);
        @(negedge clk);
        chk(nm, 32'(rd_char), 32'(exp));
    endtask

    function automatic logic [7:0] pick_byte();
        int r = $urandom_range(0, 399);
        if (r < 240) return 8'($urandom_range(32, 126));
        if (r < 270) return 8'h0D;
        if (r < 300) return 8'h0A;
        if (r < 340) return 8'h08;
        if (r == 340) return 8'h0C;
        if (r < 370) return 8'($urandom_range(0, 31));
        return 8'($urandom_range(128, 255));
    endfunction

    initial begin
        int cnt;
        int rate;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rd_col   = 7'd0;
        rd_row   = 5'd0;
        tx_busy  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_rd_char", 32'(rd_char), 32'h0);
        chk("reset_overrun", 32'(overrun), 32'h0);
        chk("reset_tx_start", 32'(tx_start), 32'h0);

        // Full clear after reset release: busy exactly ROWS*COLS cycles.
        reset = 1'b0;
        cnt   = 0;
        while (busy === 1'b1 && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        chk("busy_cycles_after_reset", 32'(cnt), 32'd2400);
        chk("cursor_col_after_clear", 32'(cur_col), 32'd0);
        chk("cursor_row_after_clear", 32'(cur_row), 32'd0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                read_chk("cell_blank_after_reset", r, c, 8'h20);
        read_chk("oor_col_blank", 3, 100, 8'h20);
        read_chk("oor_row_blank", 31, 3, 8'h20);

        // Single printable: cursor moves one edge after the strobe is sampled.
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("latency_cursor_unmoved", 32'(cur_col), 32'd0);
        @(negedge clk);
        chk("A_cursor_col", 32'(cur_col), 32'd1);
        chk("A_cursor_row", 32'(cur_row), 32'd0);
        read_chk("A_read_back", 0, 0, 8'h41);

        // Full line of printables wraps to the next (cleared) row.
        send(8'h0D);
        wait_idle(10);
        for (int i = 0; i < COLS; i++) begin
            send(8'h30 + 8'(i % 40));
            repeat (99) @(negedge clk);
        end
        wait_idle(200);
        chk("line_wrap_col", 32'(cur_col), 32'd0);
        chk("line_wrap_row", 32'(cur_row), 32'd1);
        read_chk("row0_col5", 0, 5, 8'h35);
        read_chk("row0_col79", 0, 79, 8'h57);
        read_chk("row1_col0_blank", 1, 0, 8'h20);
        read_chk("row1_col79_blank", 1, 79, 8'h20);
        send(8'h08);
        wait_idle(10);
        chk("bs_col0_col", 32'(cur_col), 32'd0);
        chk("bs_col0_row", 32'(cur_row), 32'd1);

        // Walk to the last row, leaving a marker on row 5, then wrap.
        for (int k = 0; k < 28; k++) begin
            if (k == 4) begin
                send(8'h51);
                wait_idle(10);
            end
            send(8'h0A);
            wait_idle(200);
        end
        chk("row_before_wrap", 32'(cur_row), 32'd29);
        rx_valid = 1'b1;
        rx_data  = 8'h0A;
        @(negedge clk);
        rx_valid = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        // one WRITE cycle plus COLS clear cycles
        chk("lf_wrap_busy_cycles", 32'(cnt), 32'd81);
        chk("lf_wrap_row", 32'(cur_row), 32'd0);
        chk("lf_wrap_col", 32'(cur_col), 32'd1);
        read_chk("row0_cleared_col5", 0, 5, 8'h20);
        read_chk("row0_cleared_col79", 0, 79, 8'h20);
        read_chk("row5_intact", 5, 0, 8'h51);

        // Bytes during a full clear: first held, the rest dropped.
        send(8'h0C);
        repeat (10) @(negedge clk);
        send(8'h41);
        repeat (5) @(negedge clk);
        send(8'h42);
        chk("overrun_set", 32'(overrun), 32'd1);
        repeat (5) @(negedge clk);
        send(8'h43);
        wait_idle(3000);
        repeat (3) @(negedge clk);
        chk("held_cursor_col", 32'(cur_col), 32'd1);
        chk("held_cursor_row", 32'(cur_row), 32'd0);
        read_chk("held_byte_written", 0, 0, 8'h41);
        read_chk("dropped_not_written", 0, 1, 8'h20);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        send(8'h0C);
        @(negedge clk);
        chk("overrun_cleared_by_ff", 32'(overrun), 32'd0);
        wait_idle(3000);

        // Echo path.
        tx_busy  = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
`ifdef TEXT_ECHO_EN
        chk("echo_start", 32'(tx_start), 32'd1);
        chk("echo_data", 32'(tx_data), 32'h5A);
        @(negedge clk);
        chk("echo_one_cycle", 32'(tx_start), 32'd0);
`else
        chk("no_echo_start", 32'(tx_start), 32'd0);
        chk("no_echo_data", 32'(tx_data), 32'd0);
        @(negedge clk);
`endif
        tx_busy  = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("echo_skipped_tx_busy", 32'(tx_start), 32'd0);
        tx_busy = 1'b0;
        read_chk("echo_byte0_written", 0, 0, 8'h5A);
        read_chk("echo_byte1_written", 0, 1, 8'h5A);

        // Randomized traffic with one reset in the middle.
        rate = 4;
        for (int i = 0; i < 20000; i++) begin
            if (i % 500 == 0) rate = $urandom_range(1, 8);
            rd_row  = 5'($urandom_range(0, 31));
            rd_col  = 7'($urandom_range(0, 127));
            tx_busy = ($urandom_range(0, 3) == 0);
            reset   = (i == 9000);
            if ($urandom_range(1, rate) == 1) begin
                rx_valid = 1'b1;
                rx_data  = pick_byte();
            end else begin
                rx_valid = 1'b0;
            end
            @(negedge clk);
        end
        reset    = 1'b0;
        rx_valid = 1'b0;
        wait_idle(6000);
        repeat (3) @(negedge clk);
        wait_idle(6000);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
